// File: rtl/dma_dev_port.sv
// Device-side transfer engine upstream of the DMA controller: latches a command,
// raises a request and moves words between the controller port and a local stream.
module dma_dev_port #(
    parameter int ADD  = 5,
    parameter int DATA = 8,
    parameter int WORD = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD:0]   in_num_words,
    input  logic [ADD-1:0]  in_start_address,
    input  logic            in_rd_wr,
    output logic            dev_ready,
    output logic            xfer_err,
    output logic [WORD:0]   num_words,
    output logic [ADD-1:0]  start_address,
    output logic            rd_wr,
    output logic            rqst,
    output logic            dev_ack,
    output logic [DATA-1:0] dev_out,
    input  logic            dma_ack,
    input  logic [DATA-1:0] dev_in,
    input  logic            dma_end_flag,
    input  logic            src_valid,
    input  logic [DATA-1:0] src_data,
    output logic            src_ready,
    output logic            snk_valid,
    output logic [DATA-1:0] snk_data
);

    typedef enum logic [2:0] {IDLE, REQ, RD_WAIT, RD_ACK, WR_FETCH, WR_WAIT, DONE} state_t;

    localparam logic [WORD:0] CNT_ONE = {{WORD{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [WORD:0]   cnt_q, cnt_d;
    logic            end_seen_q, end_seen_d;
    logic            active, early, rx_word, tx_word, cmd_load;

    logic            dev_ready_q, dev_ready_d;
    logic            xfer_err_q, xfer_err_d;
    logic [WORD:0]   num_words_q, num_words_d;
    logic [ADD-1:0]  start_address_q, start_address_d;
    logic            rd_wr_q, rd_wr_d;
    logic            rqst_q, rqst_d;
    logic            dev_ack_q, dev_ack_d;
    logic [DATA-1:0] dev_out_q, dev_out_d;
    logic            src_ready_q, src_ready_d;
    logic            snk_valid_q, snk_valid_d;
    logic [DATA-1:0] snk_data_q, snk_data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            end_seen_q      <= 1'b0;
            dev_ready_q     <= 1'b1;
            xfer_err_q      <= 1'b0;
            num_words_q     <= '0;
            start_address_q <= '0;
            rd_wr_q         <= 1'b0;
            rqst_q          <= 1'b0;
            dev_ack_q       <= 1'b0;
            dev_out_q       <= '0;
            src_ready_q     <= 1'b0;
            snk_valid_q     <= 1'b0;
            snk_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            end_seen_q      <= end_seen_d;
            dev_ready_q     <= dev_ready_d;
            xfer_err_q      <= xfer_err_d;
            num_words_q     <= num_words_d;
            start_address_q <= start_address_d;
            rd_wr_q         <= rd_wr_d;
            rqst_q          <= rqst_d;
            dev_ack_q       <= dev_ack_d;
            dev_out_q       <= dev_out_d;
            src_ready_q     <= src_ready_d;
            snk_valid_q     <= snk_valid_d;
            snk_data_q      <= snk_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_word  = 1'b0;
        tx_word  = 1'b0;
        cmd_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_num_words != '0) begin
                        state_d  = REQ;
                        cnt_d    = in_num_words;
                        cmd_load = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ:      state_d = rd_wr_q ? RD_WAIT : WR_FETCH;
            RD_WAIT: begin
                if (dma_ack) begin
                    rx_word = 1'b1;
                    state_d = RD_ACK;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                end
            end
            RD_ACK:   state_d = (cnt_q == '0) ? DONE : RD_WAIT;
            WR_FETCH: begin
                if (src_valid && src_ready_q) begin
                    tx_word = 1'b1;
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (dma_ack) begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                    state_d = (cnt_d == '0) ? DONE : WR_FETCH;
                end
            end
            DONE:     if (dma_end_flag || end_seen_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // End flag only counts as early when words remain after this cycle's decrement.
        active = state_q inside {RD_WAIT, RD_ACK, WR_FETCH, WR_WAIT};
        early  = active && dma_end_flag && (cnt_d != '0);
        if (early) state_d = IDLE;
    end

    always_comb begin
        dev_ready_d     = (state_d == IDLE);
        rqst_d          = state_d inside {RD_WAIT, RD_ACK, WR_FETCH, WR_WAIT};
        src_ready_d     = (state_d == WR_FETCH);
        xfer_err_d      = early;
        snk_valid_d     = rx_word && !early;
        dev_ack_d       = (state_d == RD_ACK) || (tx_word && !early);
        snk_data_d      = snk_valid_d ? dev_in : snk_data_q;
        dev_out_d       = (tx_word && !early) ? src_data : dev_out_q;
        num_words_d     = cmd_load ? in_num_words : num_words_q;
        start_address_d = cmd_load ? in_start_address : start_address_q;
        rd_wr_d         = cmd_load ? in_rd_wr : rd_wr_q;
        // A zero-length command or an end flag seen with the last word lets DONE exit at once.
        end_seen_d      = end_seen_q;
        if (state_d == IDLE)
            end_seen_d = 1'b0;
        else if (state_q == IDLE && state_d == DONE)
            end_seen_d = 1'b1;
        else if (active && dma_end_flag)
            end_seen_d = 1'b1;
    end

    assign dev_ready     = dev_ready_q;
    assign xfer_err      = xfer_err_q;
    assign num_words     = num_words_q;
    assign start_address = start_address_q;
    assign rd_wr         = rd_wr_q;
    assign rqst          = rqst_q;
    assign dev_ack       = dev_ack_q;
    assign dev_out       = dev_out_q;
    assign src_ready     = src_ready_q;
    assign snk_valid     = snk_valid_q;
    assign snk_data      = snk_data_q;

endmodule

// File: tb/tb_dma_dev_port.sv
// Directed bench for dma_dev_port: per-cycle vector table plus hand-written
// sequences for the 16-word write and mid-transfer reset.
module tb_dma_dev_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] in_num_words;
    logic [4:0] in_start_address;
    logic       in_rd_wr;
    logic       dev_ready, xfer_err, rd_wr, rqst, dev_ack, src_ready, snk_valid;
    logic [4:0] num_words, start_address;
    logic [7:0] dev_out, snk_data;
    logic       dma_ack, dma_end_flag, src_valid;
    logic [7:0] dev_in, src_data;

    int errors = 0;
    int checks = 0;
    int unsigned ack_cnt = 0;
    int unsigned err_cnt = 0;

    dma_dev_port #(.ADD(5), .DATA(8), .WORD(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_num_words(in_num_words),
        .in_start_address(in_start_address), .in_rd_wr(in_rd_wr),
        .dev_ready(dev_ready), .xfer_err(xfer_err), .num_words(num_words),
        .start_address(start_address), .rd_wr(rd_wr), .rqst(rqst),
        .dev_ack(dev_ack), .dev_out(dev_out), .dma_ack(dma_ack), .dev_in(dev_in),
        .dma_end_flag(dma_end_flag), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .snk_valid(snk_valid), .snk_data(snk_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset && dev_ack) ack_cnt++;
    always @(negedge clk) if (reset && xfer_err) err_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       st;
        logic [4:0] nw;
        logic [4:0] ad;
        logic       rw;
        logic       ack;
        logic [7:0] din;
        logic       ef;
        logic       sv;
        logic [7:0] sd;
        logic [32:0] exp;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic st, logic [4:0] nw, logic [4:0] ad, logic rw,
                                logic ack, logic [7:0] din, logic ef, logic sv,
                                logic [7:0] sd, logic [32:0] exp);
        vec_t v;
        v.st = st; v.nw = nw; v.ad = ad; v.rw = rw; v.ack = ack;
        v.din = din; v.ef = ef; v.sv = sv; v.sd = sd; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] snap();
        return {dev_ready, rqst, dev_ack, snk_valid, src_ready, xfer_err,
                snk_data, dev_out, num_words, start_address, rd_wr};
    endfunction

    task automatic idle_inputs();
        start = 1'b0; in_num_words = '0; in_start_address = '0; in_rd_wr = 1'b0;
        dma_ack = 1'b0; dev_in = '0; dma_end_flag = 1'b0; src_valid = 1'b0; src_data = '0;
    endtask

    // Source presents one word after a random gap; controller acks after another gap.
    task automatic wr_word(input logic [7:0] d, input logic exp_rqst);
        bit ok;
        int unsigned gap;
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        src_valid = 1'b1;
        src_data  = d;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (src_ready) ok = 1'b1;
            tick();
        end
        src_valid = 1'b0;
        src_data  = 8'hEE;
        chk("wr_handshake", 64'(ok), 64'(1));
        chk("wr_dev_ack", 64'(dev_ack), 64'(1));
        chk("wr_dev_out", 64'(dev_out), 64'(d));
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
        chk("wr_dev_out_hold", 64'(dev_out), 64'(d));
        chk("wr_rqst_after_ack", 64'(rqst), 64'(exp_rqst));
    endtask

    initial begin
        int unsigned ack_base, err_base;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        chk("reset_state", 64'(snap()), 64'({6'b100000, 8'h00, 8'h00, 5'd0, 5'h00, 1'b0}));

        // flags = {dev_ready, rqst, dev_ack, snk_valid, src_ready, xfer_err}
        tbl[0]  = mk(1, 1, 5'h00, 1, 0, 8'h00, 0, 0, 8'h00, {6'b000000, 8'h00, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[1]  = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b010000, 8'h00, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[2]  = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b010000, 8'h00, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[3]  = mk(0, 0, 5'h00, 0, 1, 8'hA5, 0, 0, 8'h00, {6'b011100, 8'hA5, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[4]  = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b000000, 8'hA5, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[5]  = mk(0, 0, 5'h00, 0, 0, 8'h00, 1, 0, 8'h00, {6'b100000, 8'hA5, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[6]  = mk(1, 0, 5'h03, 0, 0, 8'h00, 0, 0, 8'h00, {6'b000000, 8'hA5, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[7]  = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b100000, 8'hA5, 8'h00, 5'd1, 5'h00, 1'b1});
        tbl[8]  = mk(1, 5, 5'h0A, 1, 0, 8'h00, 0, 0, 8'h00, {6'b000000, 8'hA5, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[9]  = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b010000, 8'hA5, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[10] = mk(0, 0, 5'h00, 0, 1, 8'h11, 0, 0, 8'h00, {6'b011100, 8'h11, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[11] = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b010000, 8'h11, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[12] = mk(0, 0, 5'h00, 0, 1, 8'h22, 0, 0, 8'h00, {6'b011100, 8'h22, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[13] = mk(1, 9, 5'h1F, 0, 0, 8'h00, 0, 0, 8'h00, {6'b010000, 8'h22, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[14] = mk(0, 0, 5'h00, 0, 0, 8'h00, 1, 0, 8'h00, {6'b100001, 8'h22, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[15] = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b100000, 8'h22, 8'h00, 5'd5, 5'h0A, 1'b1});
        tbl[16] = mk(1, 1, 5'h07, 0, 0, 8'h00, 0, 0, 8'h00, {6'b000000, 8'h22, 8'h00, 5'd1, 5'h07, 1'b0});
        tbl[17] = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b010010, 8'h22, 8'h00, 5'd1, 5'h07, 1'b0});
        tbl[18] = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 1, 8'h5C, {6'b011000, 8'h22, 8'h5C, 5'd1, 5'h07, 1'b0});
        tbl[19] = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 1, 8'h77, {6'b010000, 8'h22, 8'h5C, 5'd1, 5'h07, 1'b0});
        tbl[20] = mk(0, 0, 5'h00, 0, 1, 8'h00, 1, 0, 8'h00, {6'b000000, 8'h22, 8'h5C, 5'd1, 5'h07, 1'b0});
        tbl[21] = mk(0, 0, 5'h00, 0, 0, 8'h00, 0, 0, 8'h00, {6'b100000, 8'h22, 8'h5C, 5'd1, 5'h07, 1'b0});

        for (int i = 0; i < 22; i++) begin
            start = tbl[i].st; in_num_words = tbl[i].nw; in_start_address = tbl[i].ad;
            in_rd_wr = tbl[i].rw; dma_ack = tbl[i].ack; dev_in = tbl[i].din;
            dma_end_flag = tbl[i].ef; src_valid = tbl[i].sv; src_data = tbl[i].sd;
            tick();
            chk($sformatf("vec%0d", i), 64'(snap()), 64'(tbl[i].exp));
        end
        idle_inputs();
        tick();

        // 16-word write with random source and controller gaps
        ack_base = ack_cnt;
        err_base = err_cnt;
        start = 1'b1; in_num_words = 5'd16; in_start_address = 5'h12; in_rd_wr = 1'b0;
        tick();
        idle_inputs();
        chk("wr16_latched", 64'({num_words, start_address, rd_wr}), 64'({5'd16, 5'h12, 1'b0}));
        for (int w = 0; w < 16; w++) wr_word(8'(w), (w != 15));
        chk("wr16_ack_count", 64'(ack_cnt - ack_base), 64'(16));
        chk("wr16_done_ready", 64'(dev_ready), 64'(0));
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        chk("wr16_complete", 64'({dev_ready, rqst}), 64'(2'b10));
        chk("wr16_no_err", 64'(err_cnt - err_base), 64'(0));

        // reset in the middle of an 8-word write
        start = 1'b1; in_num_words = 5'd8; in_start_address = 5'h05; in_rd_wr = 1'b0;
        tick();
        idle_inputs();
        for (int w = 0; w < 3; w++) wr_word(8'(8'h30 + w), 1'b1);
        chk("mid_rqst_before_reset", 64'(rqst), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_outputs", 64'(snap()), 64'({6'b100000, 8'h00, 8'h00, 5'd0, 5'h00, 1'b0}));
        @(posedge clk);
        #3 reset = 1'b1;
        tick();

        start = 1'b1; in_num_words = 5'd2; in_start_address = 5'h09; in_rd_wr = 1'b1;
        tick();
        idle_inputs();
        chk("rd2_latched", 64'({dev_ready, rqst, num_words, start_address, rd_wr}),
            64'({1'b0, 1'b0, 5'd2, 5'h09, 1'b1}));
        tick();
        chk("rd2_rqst", 64'(rqst), 64'(1));
        dma_ack = 1'b1; dev_in = 8'h3C;
        tick();
        dma_ack = 1'b0; dev_in = 8'h00;
        chk("rd2_word0", 64'({snk_valid, dev_ack, snk_data}), 64'({1'b1, 1'b1, 8'h3C}));
        tick();
        chk("rd2_gap", 64'({snk_valid, dev_ack, rqst}), 64'(3'b001));
        dma_ack = 1'b1; dev_in = 8'hC3;
        tick();
        dma_ack = 1'b0; dev_in = 8'h00;
        chk("rd2_word1", 64'({snk_valid, dev_ack, snk_data}), 64'({1'b1, 1'b1, 8'hC3}));
        tick();
        chk("rd2_done", 64'({dev_ready, rqst}), 64'(2'b00));
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        chk("rd2_complete", 64'({dev_ready, xfer_err}), 64'(2'b10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_dev_port.md
# dma_dev_port

Device-side transfer engine sitting directly upstream of `dma_controller`: it accepts a transfer command from higher logic, raises a request toward the DMA controller, and moves words between the controller's device port and a local stream interface. It has two directions: read (memory → device, words to a sink) and write (device → memory, words from a source). It counts words, detects early termination, and reports completion via `dev_ready`.

## Interface
- `ADD`, 5, address width
- `DATA`, 8, data word width
- `WORD`, 4, log2 of max burst; count width is WORD+1

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  command strobe from higher logic, sampled only in IDLE
- `in_num_words`  in  WORD+1  words to transfer
- `in_start_address`  in  ADD  first memory address
- `in_rd_wr`  in  1  1 = read (memory→device), 0 = write (device→memory)
- `dev_ready`  out  1  high when idle, ready for a command
- `xfer_err`  out  1  one-cycle pulse on early termination
- `num_words`  out  WORD+1  latched count to controller
- `start_address`  out  ADD  latched address to controller
- `rd_wr`  out  1  latched direction to controller
- `rqst`  out  1  transfer request, held for whole transfer
- `dev_ack`  out  1  per-word strobe to controller
- `dev_out`  out  DATA  write data to controller
- `dma_ack`  in  1  per-word strobe from controller
- `dev_in`  in  DATA  read data from controller
- `dma_end_flag`  in  1  controller end-of-transfer
- `src_valid`  in  1 / `src_data` in DATA / `src_ready` out 1: write-direction source stream
- `snk_valid`  out  1 / `snk_data` out DATA: read-direction sink, no backpressure

## Operation
- States: IDLE, REQ, RD_WAIT, RD_ACK, WR_FETCH, WR_WAIT, DONE.
- IDLE: `dev_ready`=1. On `start`=1 with `in_num_words`≠0: latch address/count/direction into output regs, load `cnt`←`in_num_words`, go REQ. `start` with count 0: go DONE directly, `rqst` never asserted.
- REQ: `rqst`=1 (stays 1 through RD_*/WR_*); go RD_WAIT if `rd_wr`=1, else WR_FETCH.
- RD_WAIT: on `dma_ack`: `snk_data`←`dev_in`, `snk_valid` pulse, `cnt`−1, go RD_ACK.
- RD_ACK: `dev_ack`=1 one cycle; if `cnt`=0 go DONE, else RD_WAIT.
- WR_FETCH: `src_ready`=1; on `src_valid`: `dev_out`←`src_data`, go WR_WAIT with `dev_ack`=1 for first cycle only.
- WR_WAIT: `dev_out` held; on `dma_ack`: `cnt`−1; `cnt` becomes 0 → DONE, else WR_FETCH.
- DONE: `rqst`=0; wait for `dma_end_flag` (or immediate if count was 0), then IDLE.
- Early termination: `dma_end_flag`=1 in RD_WAIT/RD_ACK/WR_FETCH/WR_WAIT with `cnt`≠0 after any same-cycle decrement → `xfer_err` pulse, `rqst`=0, go IDLE. `dma_end_flag` together with the last `dma_ack` is a normal finish.
- `cnt` is WORD+1 bits, decrement only when ≠0, never wraps.
- `start` outside IDLE ignored; command inputs not re-sampled mid-transfer.

## Timing
- Reset (any state, asynchronous): state IDLE, `dev_ready`=1, `rqst`=`dev_ack`=`snk_valid`=`src_ready`=`xfer_err`=0, `rd_wr`=0, `num_words`=`start_address`=`dev_out`=`snk_data`=`cnt`=0. Mid-transfer reset drops `rqst` immediately.
- `start` at edge N → `dev_ready`=0, outputs latched after N; `rqst`=1 after N+1.
- Read: `dma_ack` at edge M → `snk_valid`=1 and `dev_ack`=1 during cycle after M (same cycle), each one cycle.
- Write: `src_valid`&`src_ready` at edge M → `dev_out` valid and `dev_ack`=1 cycle after M; `dev_out` stable until `dma_ack`.
- Completion: `dma_end_flag` in DONE at edge K → `dev_ready`=1 after K (rising edge used as done by higher logic).
- All outputs registered.

## Test plan
- Read 1 word, addr 0: `start`, `in_rd_wr`=1, count 1; controller `dma_ack` with `dev_in`=0xA5 → `snk_data`=0xA5 one pulse, one `dev_ack`, `dma_end_flag` → `dev_ready` rises, no `xfer_err`.
- Write 16 words (count 16, WORD=4), source 0x00..0x0F with random `src_valid` gaps → `dev_out` sequence 0x00..0x0F, exactly 16 `dev_ack` pulses, `rqst` drops after 16th `dma_ack`.
- Count 0 → `rqst` never high, `dev_ready` returns high within 2 cycles.
- `dma_end_flag` after 2 of 5 read words → `xfer_err` one pulse, `rqst`=0, IDLE; next `start` works normally.
- Reset asserted low mid-write (after 3 words) → all outputs at reset values immediately; post-release read of 2 words completes correctly.
- `start` pulsed during active transfer → ignored; latched `num_words`/`start_address` unchanged.
